// File: rtl/timer.sv
// Memory-mapped 8-bit timer/counter: prescaled tick, programmable top,
// sticky match flag and level interrupt.
module timer #(
    parameter logic [7:0] TOP_RESET = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       writeEnable,
    input  logic       readEnable,
    input  logic [1:0] regSelect,
    input  logic [7:0] writeData,
    output logic [7:0] Data,
    output logic       irq
);

    localparam logic [1:0] SEL_CTRL  = 2'd0;
    localparam logic [1:0] SEL_PRE   = 2'd1;
    localparam logic [1:0] SEL_TOP   = 2'd2;
    localparam logic [1:0] SEL_COUNT = 2'd3;

    logic       en_q, en_d;
    logic       auto_q, auto_d;
    logic       ie_q, ie_d;
    logic       match_q, match_d;
    logic [7:0] pre_q, pre_d;
    logic [7:0] top_q, top_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] ps_q, ps_d;

    logic wr_ctrl, wr_pre, wr_top, wr_cnt;
    logic tick, hit;

    assign wr_ctrl = writeEnable && (regSelect == SEL_CTRL);
    assign wr_pre  = writeEnable && (regSelect == SEL_PRE);
    assign wr_top  = writeEnable && (regSelect == SEL_TOP);
    assign wr_cnt  = writeEnable && (regSelect == SEL_COUNT);

    assign tick = en_q && (ps_q == pre_q);
    assign hit  = tick && (cnt_q == top_q);

    always_comb begin
        en_d    = en_q;
        auto_d  = auto_q;
        ie_d    = ie_q;
        match_d = match_q;
        pre_d   = pre_q;
        top_d   = top_q;
        cnt_d   = cnt_q;
        ps_d    = ps_q;

        if (en_q) begin
            ps_d = tick ? 8'd0 : ps_q + 8'd1;
        end
        if (tick) begin
            cnt_d = hit ? 8'd0 : cnt_q + 8'd1;
        end
        if (hit && !auto_q) begin
            en_d = 1'b0;
        end

        // A tick's match outranks a same-edge software clear
        if (wr_ctrl && writeData[7]) begin
            match_d = 1'b0;
        end
        if (hit) begin
            match_d = 1'b1;
        end

        if (wr_ctrl) begin
            en_d   = writeData[0];
            auto_d = writeData[1];
            ie_d   = writeData[2];
        end
        if (wr_pre) begin
            pre_d = writeData;
        end
        if (wr_top) begin
            top_d = writeData;
        end
        if (wr_cnt) begin
            cnt_d = writeData;
            ps_d  = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            en_q    <= 1'b0;
            auto_q  <= 1'b0;
            ie_q    <= 1'b0;
            match_q <= 1'b0;
            pre_q   <= 8'd0;
            top_q   <= TOP_RESET;
            cnt_q   <= 8'd0;
            ps_q    <= 8'd0;
        end else begin
            en_q    <= en_d;
            auto_q  <= auto_d;
            ie_q    <= ie_d;
            match_q <= match_d;
            pre_q   <= pre_d;
            top_q   <= top_d;
            cnt_q   <= cnt_d;
            ps_q    <= ps_d;
        end
    end

    always_comb begin
        Data = 8'h00;
        if (readEnable) begin
            unique case (regSelect)
                SEL_CTRL:  Data = {match_q, 4'b0000, ie_q, auto_q, en_q};
                SEL_PRE:   Data = pre_q;
                SEL_TOP:   Data = top_q;
                SEL_COUNT: Data = cnt_q;
                default:   Data = 8'h00;
            endcase
        end
    end

    assign irq = match_q & ie_q;

endmodule

// File: tb/tb_timer.sv
// Bench for timer: register vector table plus timed sequences, read
// expectations queued as each read is driven and popped when data is sampled.
module tb_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       writeEnable;
    logic       readEnable;
    logic [1:0] regSelect;
    logic [7:0] writeData;
    logic [7:0] Data;
    logic       irq;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } sb_t;

    sb_t sbq[$];

    typedef struct {
        logic       we;
        logic       re;
        logic [1:0] sel;
        logic [7:0] wd;
        logic [7:0] exp_data;
        logic       exp_irq;
    } vec_t;

    vec_t vecs[16];

    timer #(.TOP_RESET(8'hFF)) dut (
        .clk        (clk),
        .reset      (reset),
        .writeEnable(writeEnable),
        .readEnable (readEnable),
        .regSelect  (regSelect),
        .writeData  (writeData),
        .Data       (Data),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: act=%02h req=%02h", name, act, exp);
        end
    endtask

    task automatic pop_chk();
        sb_t e;
        if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: act=empty req=entry");
        end else begin
            e = sbq.pop_front();
            chk(e.name, Data, e.exp);
        end
    endtask

    task automatic rd(input logic [1:0] sel, input logic [7:0] exp,
                      input string name);
        readEnable = 1'b1;
        regSelect  = sel;
        sbq.push_back('{name, exp});
        #1;
        pop_chk();
        readEnable = 1'b0;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [7:0] d);
        writeEnable = 1'b1;
        regSelect   = sel;
        writeData   = d;
        @(posedge clk);
        #1;
        writeEnable = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        // we re sel wd exp_data exp_irq
        vecs[0]  = '{1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 2'd0, 8'h00, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 2'd1, 8'h00, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 2'd2, 8'h00, 8'hFF, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 2'd3, 8'h00, 8'h00, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 2'd1, 8'h5A, 8'h00, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 2'd1, 8'h00, 8'h5A, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 2'd0, 8'h78, 8'h00, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 2'd0, 8'h00, 8'h00, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 2'd0, 8'h06, 8'h00, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 2'd0, 8'h00, 8'h06, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 2'd2, 8'h33, 8'hFF, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 2'd2, 8'h00, 8'h33, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 2'd3, 8'h12, 8'h00, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 2'd3, 8'h00, 8'h12, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 2'd3, 8'h00, 8'h00, 1'b0};

        reset       = 1'b1;
        writeEnable = 1'b0;
        readEnable  = 1'b0;
        regSelect   = 2'd0;
        writeData   = 8'h00;
        #1;
        do_reset();
        do_reset();

        // Register vectors; reads beside a write show pre-write values
        foreach (vecs[i]) begin
            writeEnable = vecs[i].we;
            readEnable  = vecs[i].re;
            regSelect   = vecs[i].sel;
            writeData   = vecs[i].wd;
            sbq.push_back('{$sformatf("vec%0d_data", i), vecs[i].exp_data});
            #1;
            pop_chk();
            chk($sformatf("vec%0d_irq", i), {7'd0, irq},
                {7'd0, vecs[i].exp_irq});
            @(posedge clk);
            #1;
            writeEnable = 1'b0;
            readEnable  = 1'b0;
        end

        // Auto-reload: PRESCALE=3, TOP=4, CTRL=07 written at edge E
        do_reset();
        wr(2'd1, 8'h03);
        wr(2'd2, 8'h04);
        wr(2'd0, 8'h07);
        idle(3);
        rd(2'd3, 8'h00, "auto_cnt_E3");
        idle(1);
        rd(2'd3, 8'h01, "auto_cnt_E4");
        idle(15);
        rd(2'd3, 8'h04, "auto_cnt_E19");
        chk("auto_irq_E19", {7'd0, irq}, 8'h00);
        idle(1);
        chk("auto_irq_E20", {7'd0, irq}, 8'h01);
        rd(2'd3, 8'h00, "auto_cnt_E20");
        rd(2'd0, 8'h87, "auto_ctrl_E20");
        wr(2'd0, 8'h87);
        chk("auto_irq_clr", {7'd0, irq}, 8'h00);
        idle(18);
        chk("auto_irq_E39", {7'd0, irq}, 8'h00);
        idle(1);
        chk("auto_irq_E40", {7'd0, irq}, 8'h01);

        // One-shot: PRESCALE=0, TOP=2, CTRL=05
        wr(2'd0, 8'h80);
        wr(2'd3, 8'h00);
        wr(2'd1, 8'h00);
        wr(2'd2, 8'h02);
        wr(2'd0, 8'h05);
        idle(2);
        rd(2'd3, 8'h02, "os_cnt_E2");
        idle(1);
        rd(2'd0, 8'h84, "os_ctrl_E3");
        chk("os_irq_E3", {7'd0, irq}, 8'h01);
        idle(10);
        rd(2'd3, 8'h00, "os_cnt_hold");
        rd(2'd0, 8'h84, "os_ctrl_hold");

        // Clear write on the match edge loses to the match
        wr(2'd3, 8'h00);
        wr(2'd0, 8'h87);
        rd(2'd0, 8'h07, "race_ctrl_E");
        idle(2);
        wr(2'd0, 8'h80);
        rd(2'd0, 8'h80, "race_ctrl_keep");
        rd(2'd3, 8'h00, "race_cnt");
        chk("race_irq", {7'd0, irq}, 8'h00);
        wr(2'd0, 8'h80);
        rd(2'd0, 8'h00, "race_ctrl_clr");
        chk("race_irq_clr", {7'd0, irq}, 8'h00);

        // COUNT above TOP wraps through FF without matching
        wr(2'd2, 8'h10);
        wr(2'd1, 8'h00);
        wr(2'd3, 8'hF0);
        wr(2'd0, 8'h05);
        idle(15);
        rd(2'd3, 8'hFF, "wrap_cnt_FF");
        idle(1);
        rd(2'd3, 8'h00, "wrap_cnt_00");
        rd(2'd0, 8'h05, "wrap_nomatch");
        idle(16);
        rd(2'd3, 8'h10, "wrap_cnt_10");
        chk("wrap_irq_pre", {7'd0, irq}, 8'h00);
        idle(1);
        chk("wrap_irq", {7'd0, irq}, 8'h01);
        rd(2'd0, 8'h84, "wrap_ctrl");

        // Reset mid-state with COUNT=3 and MATCH=1
        wr(2'd3, 8'h03);
        rd(2'd3, 8'h03, "rst_pre_cnt");
        do_reset();
        chk("rst_irq", {7'd0, irq}, 8'h00);
        chk("rst_data_idle", Data, 8'h00);
        rd(2'd0, 8'h00, "rst_ctrl");
        rd(2'd1, 8'h00, "rst_pre");
        rd(2'd2, 8'hFF, "rst_top");
        rd(2'd3, 8'h00, "rst_cnt");
        idle(5);
        rd(2'd3, 8'h00, "rst_cnt_stop");

        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_leftover: act=%0d req=0", sbq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timer.md
# timer

Memory-mapped 8-bit timer/counter peripheral on the data bus, occupying one IO slot of the memory controller alongside the UART and LED devices. It consumes the controller's per-device read/write enables, 2-bit register select and the CPU write-data bus. It returns read data combinationally for the memory read mux. It counts prescaled clock ticks up to a programmable top value, sets a sticky match flag and drives an interrupt line.

## Interface

**Parameters**
- TOP_RESET, 8'hFF, reset value of the TOP register.

**Ports**
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, synchronous active-low reset, sampled on the rising edge of clk.
- writeEnable, input, 1, slot write strobe from the memory controller.
- readEnable, input, 1, slot read strobe from the memory controller.
- regSelect, input, 2, register index.
- writeData, input, 8, CPU write data.
- Data, output, 8, read data; combinational.
- irq, output, 1, interrupt request, level.

## Operation

**Register map (regSelect)**
- 0 CTRL
  - bit0 EN: enable.
  - bit1 AUTO: 1 = auto-reload, 0 = one-shot.
  - bit2 IE: interrupt enable.
  - bit7 MATCH: read returns the flag; writing 1 clears it, writing 0 has no effect.
  - bits 6:3 read 0 and ignore writes.
- 1 PRESCALE: a tick occurs every PRESCALE+1 enabled clocks.
- 2 TOP: compare/wrap value.
- 3 COUNT: read returns the current count. A write loads the count and zeroes the internal prescaler.

**Read path**
- Data = selected register when readEnable=1; otherwise Data = 8'h00.
- Reads have no side effects.

**Prescaler**
- Internal 8-bit counter PS.
- With EN=1, PS increments each clock.
- When PS==PRESCALE: a tick occurs and PS returns to 0.
- With EN=0, PS holds its value.

**Tick**
- If COUNT==TOP, all of the following occur in the same cycle:
  - MATCH is set.
  - COUNT goes to 0.
  - If AUTO=0, EN is cleared.
- Otherwise COUNT is incremented by 1.
- Comparison is equality only. If COUNT>TOP (after a software write), COUNT counts to 8'hFF and wraps to 0 without a match, then continues normally.
- TOP=0 produces a match on every tick.
- PRESCALE=0 produces a tick on every enabled clock.

**Interrupt**
- irq = MATCH & IE, decoded directly from register flops with no extra latency.

**Simultaneous events, same edge**
- MATCH set by a tick beats a software write-1 clear; the flag stays 1.
- A CTRL write sets EN/AUTO/IE from writeData. This overrides the one-shot EN clear from a tick in the same cycle. The tick's COUNT and MATCH updates still occur.
- A COUNT write overrides the tick's COUNT update and zeroes PS. A coincident match still sets MATCH.
- A TOP or PRESCALE write takes effect for comparisons starting the next cycle.
- writeEnable and readEnable together: the read shows pre-write values; the write commits at the edge.

**Reset**
- reset=0 at a rising edge, including mid-count:
  - CTRL=0, PRESCALE=0, TOP=TOP_RESET, COUNT=0, PS=0.
- Resulting outputs: irq=0; Data=0 unless readEnable=1, in which case the reset register value is shown.

## Timing

- All register writes commit on the rising edge where writeEnable=1.
- Read data is valid in the same cycle that readEnable and regSelect are valid.
- Enable-to-first-tick: if EN is written 1 at edge E with PS=0, COUNT first increments at edge E+PRESCALE+1.
- Enable-to-match: from COUNT=0 and PS=0, MATCH and irq rise at edge E+(PRESCALE+1)×(TOP+1).
  - AUTO=1: period is (PRESCALE+1)×(TOP+1) clocks thereafter.
- MATCH clear: a write-1 at edge C drops MATCH and irq after edge C, unless a coincident match occurs.
- One-shot: EN reads 0 the cycle after the matching edge. COUNT=0 and PS=0 hold from then on.

## Test plan

1. Reset, then read all four registers. Required values: 00, 00, FF, 00 (TOP_RESET=FF). irq=0. Data=00 with readEnable=0.
2. PRESCALE=3, TOP=4, CTRL=0x07 written at edge E:
   - COUNT increments at E+4, E+8, ….
   - MATCH and irq rise at E+20; COUNT=0.
   - Next match at E+40.
3. One-shot: PRESCALE=0, TOP=2, CTRL=0x05. After 3 clocks, MATCH=1, EN=0, COUNT stays 0 for 10 further clocks.
4. Write CTRL=0x80 on the exact edge of a match: MATCH stays 1. Write 0x80 one cycle later: MATCH=0, irq=0.
5. COUNT=0xF0 written with TOP=0x10, PRESCALE=0, EN=1: count runs to FF, wraps to 00 with no match, then matches at 0x10.
6. Drive reset=0 for one edge while COUNT=3 and MATCH=1: every register returns to its reset value, irq=0, and counting stays stopped.
